// File: rtl/vcop_dispatch.sv
// rtl/vcop_dispatch.sv - buffered dispatch queue from scalar core to vector coprocessor
// Tracks coprocessor-accepted but uncompleted instructions so the core can fence on idle.
module vcop_dispatch #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_OUT    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [WORD_WIDTH-1:0]       issue_instr,
    input  logic [WORD_WIDTH-1:0]       issue_xreg,
    input  logic                        flush,
    output logic                        v_valid,
    input  logic                        v_ready,
    output logic [WORD_WIDTH-1:0]       v_instr,
    output logic [WORD_WIDTH-1:0]       v_xreg,
    input  logic                        v_done,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        idle,
    output logic                        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [2*WORD_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [OW-1:0]           outstanding;
    logic                    enq;
    logic                    deq;
    logic [AW-1:0]           rd_ptr_inc;

    assign issue_ready = (count != CW'(DEPTH));
    assign v_valid     = (count != '0) && (outstanding != OW'(MAX_OUT));
    assign v_instr     = v_valid ? mem[rd_ptr][2*WORD_WIDTH-1:WORD_WIDTH] : '0;
    assign v_xreg      = v_valid ? mem[rd_ptr][WORD_WIDTH-1:0] : '0;
    assign idle        = (count == '0) && (outstanding == '0);

    // A flush drops any same-cycle push but never a same-cycle handshake.
    assign enq        = issue_valid && issue_ready && !flush;
    assign deq        = v_valid && v_ready;
    assign rd_ptr_inc = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {issue_instr, issue_xreg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (deq) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (flush) begin
                wr_ptr <= deq ? rd_ptr_inc : rd_ptr;
                count  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                case ({enq, deq})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // A completion with nothing outstanding is ignored and latched as an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (v_done && (outstanding == '0)) begin
                err <= 1'b1;
                if (deq) begin
                    outstanding <= OW'(1);
                end
            end else begin
                case ({deq, v_done})
                    2'b10:   outstanding <= outstanding + OW'(1);
                    2'b01:   outstanding <= outstanding - OW'(1);
                    default: outstanding <= outstanding;
                endcase
            end
        end
    end

endmodule
